// File: rtl/imm_extend_stage.sv
// Immediate extension with an ID/EX pipeline register.
// b_add_o is always the branch-form offset; id_ex_o/mode_o/valid_o are registered with stall/flush.
module imm_extend_stage #(
   parameter int IN_W    = 16,
   parameter int OUT_W   = 32,
   parameter int B_SHIFT = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [1:0]       mode_i,
   input  logic [IN_W-1:0]  if_id_i,
   output logic [OUT_W-1:0] b_add_o,
   output logic [OUT_W-1:0] id_ex_o,
   output logic [1:0]       mode_o,
   output logic             valid_o
);

   localparam logic [1:0] MODE_SEXT   = 2'd0;
   localparam logic [1:0] MODE_ZEXT   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   localparam int UP_OFS = OUT_W - IN_W;

   logic [OUT_W-1:0] sext_w;
   logic [OUT_W-1:0] zext_w;
   logic [OUT_W-1:0] upper_w;
   logic [OUT_W-1:0] branch_w;
   logic [OUT_W-1:0] ext_w;

   logic [OUT_W-1:0] id_ex_q, id_ex_d;
   logic [1:0]       mode_q,  mode_d;
   logic             valid_q, valid_d;

   // Bitwise construction keeps IN_W == OUT_W legal (no zero-width replications).
   for (genvar i = 0; i < OUT_W; i++) begin : g_ext
      if (i < IN_W) begin : g_low
         assign sext_w[i] = if_id_i[i];
         assign zext_w[i] = if_id_i[i];
      end else begin : g_high
         assign sext_w[i] = if_id_i[IN_W-1];
         assign zext_w[i] = 1'b0;
      end
      if (i >= UP_OFS) begin : g_up
         assign upper_w[i] = if_id_i[i-UP_OFS];
      end else begin : g_up_zero
         assign upper_w[i] = 1'b0;
      end
   end

   assign branch_w = sext_w << B_SHIFT;
   assign b_add_o  = branch_w;

   always_comb begin
      ext_w = sext_w;
      unique case (mode_i)
         MODE_SEXT:   ext_w = sext_w;
         MODE_ZEXT:   ext_w = zext_w;
         MODE_UPPER:  ext_w = upper_w;
         MODE_BRANCH: ext_w = branch_w;
         default:     ext_w = sext_w;
      endcase
   end

   always_comb begin
      id_ex_d = id_ex_q;
      mode_d  = mode_q;
      valid_d = valid_q;
      if (flush_i) begin
         id_ex_d = '0;
         mode_d  = MODE_SEXT;
         valid_d = 1'b0;
      end else if (!stall_i) begin
         // Loaded even for bubbles; consumers qualify with valid_o.
         id_ex_d = ext_w;
         mode_d  = mode_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         id_ex_q <= '0;
         mode_q  <= MODE_SEXT;
         valid_q <= 1'b0;
      end else begin
         id_ex_q <= id_ex_d;
         mode_q  <= mode_d;
         valid_q <= valid_d;
      end
   end

   assign id_ex_o = id_ex_q;
   assign mode_o  = mode_q;
   assign valid_o = valid_q;

endmodule
